// File: rtl/axi_wr2ram_bridge.sv
// AXI write slave bridged onto a single-port RAM write port.
// AW requests are queued; one burst is serviced at a time, with FIXED/INCR
// addressing, narrow-transfer lane masking and a per-beat range check.
// Each burst's response (OKAY/SLVERR) goes into a small B queue.
module axi_wr2ram_bridge #(
    parameter int AXI_AWIDTH  = 32,
    parameter int AXI_DWIDTH  = 32,
    parameter int AXI_IDWIDTH = 3,
    parameter int AXI_LWIDTH  = 8,
    parameter int RAM_AWIDTH  = 10,
    parameter int AW_DEPTH    = 4,
    parameter int B_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXI_IDWIDTH-1:0]   axi_aw_id,
    input  logic [AXI_AWIDTH-1:0]    axi_aw_addr,
    input  logic [AXI_LWIDTH-1:0]    axi_aw_len,
    input  logic [2:0]               axi_aw_size,
    input  logic [1:0]               axi_aw_burst,
    input  logic                     axi_aw_valid,
    output logic                     axi_aw_ready,
    input  logic [AXI_DWIDTH-1:0]    axi_w_data,
    input  logic [AXI_DWIDTH/8-1:0]  axi_w_strb,
    input  logic                     axi_w_last,
    input  logic                     axi_w_valid,
    output logic                     axi_w_ready,
    output logic [AXI_IDWIDTH-1:0]   axi_b_id,
    output logic [1:0]               axi_b_resp,
    output logic                     axi_b_valid,
    input  logic                     axi_b_ready,
    output logic                     ram_wr_en,
    output logic [RAM_AWIDTH-1:0]    ram_wr_addr,
    output logic [AXI_DWIDTH-1:0]    ram_wr_data,
    output logic [AXI_DWIDTH/8-1:0]  ram_wr_be
);

    localparam int NB     = AXI_DWIDTH / 8;
    localparam int LOG2NB = $clog2(NB);
    localparam int AW_PW  = $clog2(AW_DEPTH);
    localparam int B_PW   = $clog2(B_DEPTH);
    localparam int AW_EW  = AXI_IDWIDTH + AXI_AWIDTH + AXI_LWIDTH + 5;
    localparam int B_EW   = AXI_IDWIDTH + 2;

    typedef enum logic [0:0] {IDLE, BURST} state_t;

    state_t state, next_state;

    logic [AW_EW-1:0]       aw_mem [AW_DEPTH];
    logic [AW_PW:0]         aw_wr_ptr, aw_rd_ptr;
    logic                   aw_full, aw_empty, aw_push, aw_pop;
    logic [AXI_IDWIDTH-1:0] h_id;
    logic [AXI_AWIDTH-1:0]  h_addr;
    logic [AXI_LWIDTH-1:0]  h_len;
    logic [2:0]             h_size;
    logic [1:0]             h_burst;

    logic [B_EW-1:0]        b_mem [B_DEPTH];
    logic [B_PW:0]          b_wr_ptr, b_rd_ptr;
    logic                   b_full, b_empty, b_push, b_pop;
    logic [AXI_IDWIDTH-1:0] b_head_id;
    logic [1:0]             b_head_resp;

    logic [AXI_IDWIDTH-1:0] cur_id;
    logic [AXI_AWIDTH-1:0]  cur_addr;
    logic [AXI_LWIDTH-1:0]  cur_len;
    logic [2:0]             cur_size;
    logic                   cur_fixed;
    logic                   err;
    logic [AXI_LWIDTH:0]    beat_cnt;

    logic                   w_hs, beat_last, in_range, do_write, err_next;
    logic [NB-1:0]          lane_mask;
    logic [AXI_AWIDTH-1:0]  step, incr_addr;

    // AW queue: ready whenever there is room for another request
    assign aw_full      = (aw_wr_ptr[AW_PW] != aw_rd_ptr[AW_PW]) &&
                          (aw_wr_ptr[AW_PW-1:0] == aw_rd_ptr[AW_PW-1:0]);
    assign aw_empty     = (aw_wr_ptr == aw_rd_ptr);
    assign axi_aw_ready = !aw_full;
    assign aw_push      = axi_aw_valid && axi_aw_ready;
    assign {h_id, h_addr, h_len, h_size, h_burst} = aw_mem[aw_rd_ptr[AW_PW-1:0]];

    // AW queue storage, written on each accepted request
    always_ff @(posedge clk) begin
        if (aw_push) begin
            aw_mem[aw_wr_ptr[AW_PW-1:0]] <= {axi_aw_id, axi_aw_addr, axi_aw_len, axi_aw_size, axi_aw_burst};
        end
    end

    // AW queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_wr_ptr <= '0;
            aw_rd_ptr <= '0;
        end else begin
            if (aw_push) aw_wr_ptr <= aw_wr_ptr + (AW_PW+1)'(1);
            if (aw_pop)  aw_rd_ptr <= aw_rd_ptr + (AW_PW+1)'(1);
        end
    end

    // B queue: head is presented while non-empty, outputs forced to zero when empty
    assign b_full      = (b_wr_ptr[B_PW] != b_rd_ptr[B_PW]) &&
                         (b_wr_ptr[B_PW-1:0] == b_rd_ptr[B_PW-1:0]);
    assign b_empty     = (b_wr_ptr == b_rd_ptr);
    assign axi_b_valid = !b_empty;
    assign b_pop       = axi_b_valid && axi_b_ready;
    assign {b_head_id, b_head_resp} = b_mem[b_rd_ptr[B_PW-1:0]];
    assign axi_b_id    = b_empty ? '0 : b_head_id;
    assign axi_b_resp  = b_empty ? 2'b00 : b_head_resp;

    // B queue storage, written when a burst's final beat is accepted
    always_ff @(posedge clk) begin
        if (b_push) begin
            b_mem[b_wr_ptr[B_PW-1:0]] <= {cur_id, err_next ? 2'b10 : 2'b00};
        end
    end

    // B queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            b_wr_ptr <= '0;
            b_rd_ptr <= '0;
        end else begin
            if (b_push) b_wr_ptr <= b_wr_ptr + (B_PW+1)'(1);
            if (b_pop)  b_rd_ptr <= b_rd_ptr + (B_PW+1)'(1);
        end
    end

    // Per-beat decode: handshake, last-beat detect, range check and error update
    assign w_hs      = axi_w_valid && axi_w_ready;
    assign beat_last = (beat_cnt == {1'b0, cur_len});
    assign in_range  = (cur_addr[AXI_AWIDTH-1:RAM_AWIDTH+LOG2NB] == '0);
    assign do_write  = w_hs && in_range && !err;
    assign err_next  = err || !in_range || (axi_w_last != beat_last);

    // INCR step: align to transfer size, then advance by one transfer
    assign step      = AXI_AWIDTH'(1) << cur_size;
    assign incr_addr = (cur_addr & ~(step - AXI_AWIDTH'(1))) + step;

    // Lane mask: lanes sharing the size-aligned group that contains the address
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NB; i++) begin
            lane_mask[i] = (((LOG2NB'(i) ^ cur_addr[LOG2NB-1:0]) >> cur_size) == '0);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // FSM next state: start a burst only when a B slot is guaranteed
    always_comb begin
        next_state  = state;
        aw_pop      = 1'b0;
        axi_w_ready = 1'b0;
        b_push      = 1'b0;
        case (state)
            IDLE: begin
                if (!aw_empty && !b_full) begin
                    aw_pop     = 1'b1;
                    next_state = BURST;
                end
            end
            BURST: begin
                axi_w_ready = 1'b1;
                if (axi_w_valid && beat_last) begin
                    b_push     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Burst context: loaded on AW pop, advanced on every accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_id    <= '0;
            cur_addr  <= '0;
            cur_len   <= '0;
            cur_size  <= '0;
            cur_fixed <= 1'b0;
            err       <= 1'b0;
            beat_cnt  <= '0;
        end else if (aw_pop) begin
            cur_id    <= h_id;
            cur_addr  <= h_addr;
            cur_len   <= h_len;
            cur_size  <= h_size;
            cur_fixed <= (h_burst == 2'b00);
            err       <= h_burst[1] || (h_size > 3'(LOG2NB));
            beat_cnt  <= '0;
        end else if (w_hs) begin
            err      <= err_next;
            beat_cnt <= beat_cnt + (AXI_LWIDTH+1)'(1);
            if (!cur_fixed) cur_addr <= incr_addr;
        end
    end

    // RAM write port, registered one cycle after the accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            ram_wr_be   <= '0;
        end else begin
            ram_wr_en <= do_write;
            if (do_write) begin
                ram_wr_addr <= cur_addr[RAM_AWIDTH+LOG2NB-1:LOG2NB];
                ram_wr_data <= axi_w_data;
                ram_wr_be   <= axi_w_strb & lane_mask;
            end
        end
    end

endmodule
